// File: rtl/tnn_seq_pkg.sv
// ---------------------------------------------------------------------------
// tnn_seq_pkg
// Shared definitions for the ternary-NN batch sequencer.
//   seq_state_e       : sequencer FSM state encoding (IDLE/LOAD/RUN/HOLD)
//   width_of()        : bits needed to index n values (minimum 1)
//   core_lat_of()     : core settle time, HIDDEN_CNT + CLASS_CNT + 1
//   DEFAULT_CORE_LAT  : settle time of the default core (40 hidden, 7 classes)
// ---------------------------------------------------------------------------
package tnn_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } seq_state_e;

   // $clog2 collapses to 0 for n <= 1; a port still needs one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // One cycle per hidden neuron, one per class, plus the argmax register.
   function automatic int unsigned core_lat_of(input int unsigned hidden_cnt,
                                               input int unsigned class_cnt);
      return hidden_cnt + class_cnt + 1;
   endfunction

   localparam int unsigned DEFAULT_HIDDEN_CNT = 40;
   localparam int unsigned DEFAULT_CLASS_CNT  = 7;
   localparam int unsigned DEFAULT_CORE_LAT   =
      core_lat_of(DEFAULT_HIDDEN_CNT, DEFAULT_CLASS_CNT);

endpackage

// File: rtl/tnn_batch_sequencer_if.sv
// ---------------------------------------------------------------------------
// tnn_batch_sequencer_if
// Sample-in and result-out valid/ready streams of the batch sequencer.
// Optional macro: TNN_SEQ_ACCURACY_EN adds in_label and out_correct.
//   in_valid / in_ready / in_data [/ in_label]      : sample stream
//   out_valid / out_ready / out_pred [/ out_correct]: result stream
// Modports:
//   master : environment side (drives samples, sinks results)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface tnn_batch_sequencer_if #(
   parameter int unsigned FEAT_CNT  = 11,
   parameter int unsigned FEAT_BITS = 4,
   parameter int unsigned CLASS_CNT = 7
);
   localparam int unsigned PRED_W = tnn_seq_pkg::width_of(CLASS_CNT);
   localparam int unsigned FEAT_W = FEAT_CNT * FEAT_BITS;

   logic              in_valid;
   logic              in_ready;
   logic [FEAT_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [PRED_W-1:0] out_pred;
`ifdef TNN_SEQ_ACCURACY_EN
   logic [PRED_W-1:0] in_label;
   logic              out_correct;

   modport master (
      output in_valid, in_data, in_label, out_ready,
      input  in_ready, out_valid, out_pred, out_correct
   );

   modport slave (
      input  in_valid, in_data, in_label, out_ready,
      output in_ready, out_valid, out_pred, out_correct
   );
`else
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_pred
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_pred
   );
`endif

endinterface

// File: rtl/tnn_seq_counters.sv
// ---------------------------------------------------------------------------
// tnn_seq_counters
// Per-batch result counters for the sequencer.
// Optional macro: TNN_SEQ_ACCURACY_EN adds the correct-result counter.
//   clk, rst      : clock, synchronous active-high reset (clears counters)
//   out_hs        : a result was handed to the sink this cycle
//   out_correct   : that result matched its label (accuracy build only)
//   sample_cnt    : results delivered, saturating at TEST_CNT
//   correct_cnt   : correct results delivered (accuracy build only)
//   batch_done    : sample_cnt has reached TEST_CNT
//   last          : the next delivered result completes the batch
// ---------------------------------------------------------------------------
module tnn_seq_counters #(
   parameter int unsigned TEST_CNT = 1000,
   parameter int unsigned CNT_W    = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             out_hs,
`ifdef TNN_SEQ_ACCURACY_EN
   input  logic             out_correct,
   output logic [CNT_W-1:0] correct_cnt,
`endif
   output logic [CNT_W-1:0] sample_cnt,
   output logic             batch_done,
   output logic             last
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TEST_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TEST_CNT - 1);

   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
`ifdef TNN_SEQ_ACCURACY_EN
   logic [CNT_W-1:0] correct_cnt_q, correct_cnt_d;
`endif

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      if (out_hs && (sample_cnt_q != CNT_MAX)) begin
         sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end
   end

`ifdef TNN_SEQ_ACCURACY_EN
   // correct_cnt never exceeds sample_cnt, so the guard only matters if
   // results keep arriving after the batch has saturated.
   always_comb begin
      correct_cnt_d = correct_cnt_q;
      if (out_hs && out_correct && (correct_cnt_q != CNT_MAX)) begin
         correct_cnt_d = correct_cnt_q + CNT_W'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt_q  <= '0;
`ifdef TNN_SEQ_ACCURACY_EN
         correct_cnt_q <= '0;
`endif
      end else begin
         sample_cnt_q  <= sample_cnt_d;
`ifdef TNN_SEQ_ACCURACY_EN
         correct_cnt_q <= correct_cnt_d;
`endif
      end
   end

   assign sample_cnt  = sample_cnt_q;
`ifdef TNN_SEQ_ACCURACY_EN
   assign correct_cnt = correct_cnt_q;
`endif
   assign batch_done  = (sample_cnt_q == CNT_MAX);
   assign last        = (sample_cnt_q >= CNT_LAST);

endmodule

// File: rtl/tnn_batch_sequencer.sv
// ---------------------------------------------------------------------------
// tnn_batch_sequencer
// Feeds one sample at a time to the sequential ternary-NN core: latches the
// features, pulses the core reset for one cycle, waits CORE_LAT cycles for the
// prediction to settle, then offers the captured prediction downstream.
// Optional macro: TNN_SEQ_ACCURACY_EN (label capture, out_correct, correct_cnt).
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   bus (slave)      : sample stream in, result stream out
//   core_rst         : core reset, high during rst and the LOAD cycle
//   core_features    : registered features, change only on input handshake
//   core_prediction  : core argmax output
//   sample_cnt       : results delivered in this batch
//   correct_cnt      : correct results in this batch (accuracy build only)
//   busy             : FSM not in IDLE
//   batch_done       : TEST_CNT results delivered, input blocked until rst
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a sample (blocked once the batch is done)
// LOAD  | features latched, core held in reset for one cycle
// RUN   | core evaluating, wait counter runs 0 .. CORE_LAT-1
// HOLD  | prediction presented, waiting for the sink
// ---------------------------------------------------------------------------
module tnn_batch_sequencer
   import tnn_seq_pkg::*;
#(
   parameter  int unsigned FEAT_CNT  = 11,
   parameter  int unsigned FEAT_BITS = 4,
   parameter  int unsigned CLASS_CNT = 7,
   parameter  int unsigned CORE_LAT  = DEFAULT_CORE_LAT,
   parameter  int unsigned TEST_CNT  = 1000,
   localparam int unsigned PRED_W    = width_of(CLASS_CNT),
   localparam int unsigned CNT_W     = width_of(TEST_CNT + 1),
   localparam int unsigned FEAT_W    = FEAT_CNT * FEAT_BITS
) (
   input  logic              clk,
   input  logic              rst,
   tnn_batch_sequencer_if.slave bus,
   output logic              core_rst,
   output logic [FEAT_W-1:0] core_features,
   input  logic [PRED_W-1:0] core_prediction,
   output logic [CNT_W-1:0]  sample_cnt,
`ifdef TNN_SEQ_ACCURACY_EN
   output logic [CNT_W-1:0]  correct_cnt,
`endif
   output logic              busy,
   output logic              batch_done
);

   localparam int unsigned       WAIT_W   = width_of(CORE_LAT);
   localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(CORE_LAT - 1);

   seq_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [FEAT_W-1:0] feat_q, feat_d;
   logic [PRED_W-1:0] pred_q, pred_d;
`ifdef TNN_SEQ_ACCURACY_EN
   logic [PRED_W-1:0] label_q, label_d;
   logic              correct_q, correct_d;
`endif

   logic in_ready;
   logic out_valid;
   logic in_hs;
   logic out_hs;
   logic last;

   tnn_seq_counters #(
      .TEST_CNT (TEST_CNT),
      .CNT_W    (CNT_W)
   ) u_counters (
      .clk         (clk),
      .rst         (rst),
      .out_hs      (out_hs),
`ifdef TNN_SEQ_ACCURACY_EN
      .out_correct (correct_q),
      .correct_cnt (correct_cnt),
`endif
      .sample_cnt  (sample_cnt),
      .batch_done  (batch_done),
      .last        (last)
   );

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      feat_d    = feat_q;
      pred_d    = pred_q;
`ifdef TNN_SEQ_ACCURACY_EN
      label_d   = label_q;
      correct_d = correct_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      in_hs     = 1'b0;
      out_hs    = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = !batch_done;
            if (bus.in_valid && !batch_done) begin
               in_hs   = 1'b1;
               state_d = LOAD;
            end
         end

         LOAD: begin
            wait_d  = '0;
            state_d = RUN;
         end

         RUN: begin
            if (wait_q == WAIT_END) begin
               pred_d    = core_prediction;
`ifdef TNN_SEQ_ACCURACY_EN
               // Exact compare: an out-of-range prediction only counts
               // if the label carries the same out-of-range code.
               correct_d = (core_prediction == label_q);
`endif
               state_d   = HOLD;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         HOLD: begin
            out_valid = 1'b1;
            // A new sample rides on the result handshake unless this
            // result completes the batch.
            in_ready  = bus.out_ready && !last;
            if (bus.out_ready) begin
               out_hs = 1'b1;
               if (bus.in_valid && !last) begin
                  in_hs   = 1'b1;
                  state_d = LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      if (in_hs) begin
         feat_d  = bus.in_data;
`ifdef TNN_SEQ_ACCURACY_EN
         label_d = bus.in_label;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wait_q    <= '0;
         feat_q    <= '0;
         pred_q    <= '0;
`ifdef TNN_SEQ_ACCURACY_EN
         label_q   <= '0;
         correct_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         feat_q    <= feat_d;
         pred_q    <= pred_d;
`ifdef TNN_SEQ_ACCURACY_EN
         label_q   <= label_d;
         correct_q <= correct_d;
`endif
      end
   end

   // The core sees rst combinationally so it is held in reset in the same
   // cycle the sequencer abandons a sample.
   assign core_rst      = rst | (state_q == LOAD);
   assign core_features = feat_q;
   assign busy          = (state_q != IDLE);

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.out_pred    = pred_q;
`ifdef TNN_SEQ_ACCURACY_EN
   assign bus.out_correct = correct_q;
`endif

endmodule

// File: tb/tb_tnn_batch_sequencer.sv
module tb_tnn_batch_sequencer;
   import tnn_seq_pkg::*;

   localparam int unsigned FEAT_CNT  = 11;
   localparam int unsigned FEAT_BITS = 4;
   localparam int unsigned CLASS_CNT = 7;
   localparam int unsigned CORE_LAT  = 48;
   localparam int unsigned TEST_CNT  = 3;
   localparam int unsigned FEAT_W    = 44;
   localparam int unsigned PRED_W    = 3;
   localparam int unsigned CNT_W     = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              core_rst;
   logic [FEAT_W-1:0] core_features;
   logic [PRED_W-1:0] core_prediction;
   logic [CNT_W-1:0]  sample_cnt;
`ifdef TNN_SEQ_ACCURACY_EN
   logic [CNT_W-1:0]  correct_cnt;
`endif
   logic              busy;
   logic              batch_done;

   int cyc      = 0;
   int core_age = 0;
   int checks   = 0;
   int errors   = 0;

   typedef struct {
      logic [PRED_W-1:0] pred;
      logic              corr;
      int                rise;
   } exp_t;
   exp_t sb[$];

   tnn_batch_sequencer_if #(
      .FEAT_CNT (FEAT_CNT),
      .FEAT_BITS(FEAT_BITS),
      .CLASS_CNT(CLASS_CNT)
   ) bus ();

   tnn_batch_sequencer #(
      .FEAT_CNT (FEAT_CNT),
      .FEAT_BITS(FEAT_BITS),
      .CLASS_CNT(CLASS_CNT),
      .CORE_LAT (CORE_LAT),
      .TEST_CNT (TEST_CNT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .core_rst       (core_rst),
      .core_features  (core_features),
      .core_prediction(core_prediction),
      .sample_cnt     (sample_cnt),
`ifdef TNN_SEQ_ACCURACY_EN
      .correct_cnt    (correct_cnt),
`endif
      .busy           (busy),
      .batch_done     (batch_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Core model: the answer is the low 3 feature bits, but only once the core
   // has run CORE_LAT cycles since its reset; before that it shows the inverse.
   always @(posedge clk) begin
      if (core_rst) core_age <= 0;
      else if (core_age < 1000) core_age <= core_age + 1;
   end
   always_comb core_prediction = (core_age >= int'(CORE_LAT) - 1) ?
                                 core_features[2:0] : ~core_features[2:0];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      logic              prev_hs   = 1'b0;
      logic              prev_ov   = 1'b0;
      logic              prev_rst  = 1'b1;
      logic [FEAT_W-1:0] prev_data = '0;
      logic [FEAT_W-1:0] prev_feat = '0;
      int                exp_cnt   = 0;
      int                exp_corr  = 0;
      exp_t              e;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            exp_cnt  = 0;
            exp_corr = 0;
            prev_hs  = 1'b0;
            prev_ov  = 1'b0;
            prev_rst = 1'b1;
         end else begin
            chk("core_rst_after_accept", core_rst, prev_hs);
            if (prev_hs)
               chk("core_features_load", core_features, prev_data);
            else if (!prev_rst && core_features !== prev_feat)
               chk("core_features_stable", core_features, prev_feat);
            if (bus.out_valid && !prev_ov) begin
               if (sb.size() == 0) fail_now("unexpected_out_valid");
               else chk("out_valid_rise_cycle", cyc, sb[0].rise);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  fail_now("unexpected_result");
               end else begin
                  e = sb.pop_front();
                  chk("out_pred", bus.out_pred, e.pred);
                  chk("sample_cnt_at_handshake", sample_cnt, exp_cnt);
`ifdef TNN_SEQ_ACCURACY_EN
                  chk("out_correct", bus.out_correct, e.corr);
                  chk("correct_cnt_at_handshake", correct_cnt, exp_corr);
                  if (e.corr && exp_corr < int'(TEST_CNT)) exp_corr++;
`endif
                  if (exp_cnt < int'(TEST_CNT)) exp_cnt++;
               end
            end
            prev_hs  = bus.in_valid && bus.in_ready;
            prev_ov  = bus.out_valid;
            prev_rst = 1'b0;
         end
         prev_data = bus.in_data;
         prev_feat = core_features;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [FEAT_W-1:0] d, input logic [PRED_W-1:0] lab, output int acc);
      exp_t e;
      int   n    = 0;
      bit   done = 1'b0;
      logic [FEAT_W-1:0] dv;
      dv = d;
      acc = -1;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
`ifdef TNN_SEQ_ACCURACY_EN
      bus.in_label = lab;
`endif
      while (!done && n < 200) begin
         @(negedge clk);
         if (bus.in_ready && !rst) begin
            e.pred = dv[2:0];
            e.corr = (dv[2:0] == lab);
            e.rise = cyc + int'(CORE_LAT) + 2;
            sb.push_back(e);
            acc  = cyc;
            done = 1'b1;
         end
         @(posedge clk); #1;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!done) fail_now("in_handshake_timeout");
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) fail_now("result_timeout");
   endtask

   task automatic wait_out_valid(input int budget);
      int n = 0;
      @(negedge clk);
      while (!bus.out_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) fail_now("out_valid_timeout");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      chk("core_rst_during_rst", core_rst, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin : stim
      int acc, acc2, acc3, cnt;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
`ifdef TNN_SEQ_ACCURACY_EN
      bus.in_label  = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // reset state
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_out_pred", bus.out_pred, 3'd0);
      chk("rst_core_features", core_features, '0);
      chk("rst_sample_cnt", sample_cnt, 2'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_batch_done", batch_done, 1'b0);
      chk("rst_core_rst_low", core_rst, 1'b0);
`ifdef TNN_SEQ_ACCURACY_EN
      chk("rst_out_correct", bus.out_correct, 1'b0);
      chk("rst_correct_cnt", correct_cnt, 2'd0);
`endif
      @(posedge clk); #1;

      // single sample, prediction 3
      send(44'h000_0000_0013, 3'd3, acc);
      @(negedge clk);
      chk("single_core_rst_load", core_rst, 1'b1);
      chk("single_busy", busy, 1'b1);
      @(negedge clk);
      chk("single_core_rst_run", core_rst, 1'b0);
      wait_drain(120);
      @(negedge clk);
      chk("single_sample_cnt", sample_cnt, 2'd1);
      chk("single_busy_after", busy, 1'b0);
      @(posedge clk); #1;

      // back-to-back batch of 3: preds 1,0,3 vs labels 1,2,3
      do_reset();
      @(negedge clk);
      @(posedge clk); #1;
      send(44'hA5A_5A5A_5A51, 3'd1, acc);
      send(44'h3C3_C3C3_C3C8, 3'd2, acc2);
      chk("b2b_spacing_1", acc2 - acc, CORE_LAT + 2);
      send(44'h0F0_F0F0_F0FB, 3'd3, acc3);
      chk("b2b_spacing_2", acc3 - acc2, CORE_LAT + 2);
      wait_drain(150);
      @(negedge clk);
      chk("batch_sample_cnt", sample_cnt, 2'd3);
      chk("batch_done_set", batch_done, 1'b1);
`ifdef TNN_SEQ_ACCURACY_EN
      chk("batch_correct_cnt", correct_cnt, 2'd2);
`endif
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 44'h111_1111_1112;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("batch_done_in_ready", bus.in_ready, 1'b0);
         chk("batch_done_busy", busy, 1'b0);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      do_reset();
      @(negedge clk);
      chk("post_batch_rst_sample_cnt", sample_cnt, 2'd0);
      chk("post_batch_rst_in_ready", bus.in_ready, 1'b1);
      chk("post_batch_rst_batch_done", batch_done, 1'b0);
`ifdef TNN_SEQ_ACCURACY_EN
      chk("post_batch_rst_correct_cnt", correct_cnt, 2'd0);
`endif
      @(posedge clk); #1;

      // backpressure: pred 6, label 4
      bus.out_ready = 1'b0;
      send(44'h777_7777_7776, 3'd4, acc);
      wait_out_valid(100);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_out_valid", bus.out_valid, 1'b1);
         chk("stall_out_pred", bus.out_pred, 3'd6);
         chk("stall_sample_cnt", sample_cnt, 2'd0);
         chk("stall_in_ready", bus.in_ready, 1'b0);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_drain(5);
      @(negedge clk);
      chk("release_sample_cnt", sample_cnt, 2'd1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.out_valid) cnt++;
      end
      chk("release_single_handshake", cnt, 0);
      @(posedge clk); #1;

      // out-of-range prediction 7 with matching label, then rst in HOLD
      bus.out_ready = 1'b0;
      send(44'h123_4567_89AF, 3'd7, acc);
      wait_out_valid(100);
      chk("oor_pred_passthrough", bus.out_pred, 3'd7);
`ifdef TNN_SEQ_ACCURACY_EN
      chk("oor_label_match_correct", bus.out_correct, 1'b1);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("hold_rst_core_rst", core_rst, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("hold_rst_out_valid", bus.out_valid, 1'b0);
      chk("hold_rst_sample_cnt", sample_cnt, 2'd0);
      chk("hold_rst_busy", busy, 1'b0);
      @(posedge clk); #1;

      // rst at cycle 20 of RUN
      send(44'h0AB_CDEF_0125, 3'd5, acc);
      repeat (21) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("run_rst_core_rst", core_rst, 1'b1);
      chk("run_rst_busy_before", busy, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("run_rst_busy_after", busy, 1'b0);
      chk("run_rst_out_valid", bus.out_valid, 1'b0);
      chk("run_rst_core_rst_low", core_rst, 1'b0);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.out_valid) cnt++;
      end
      chk("run_rst_no_result", cnt, 0);
      chk("scoreboard_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog_timeout (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/tnn_batch_sequencer.md
# tnn_batch_sequencer

Sequences the sequential ternary-NN core (`seq_tnndirect`) over a stream of test samples. It accepts one feature vector at a time over a valid/ready handshake and holds it stable on the core's `features` input. It then restarts the core with a one-cycle reset, waits a fixed evaluation window, captures `prediction` and presents it downstream over valid/ready. It sits between the sample source (ROM walker or host FIFO) and the result sink, replacing free-running use of the core in the per-dataset product wrappers.

## Interface

Parameters:
- FEAT_CNT, 11, features per sample
- FEAT_BITS, 4, bits per feature
- CLASS_CNT, 7, output classes; prediction width PRED_W = $clog2(CLASS_CNT)
- CORE_LAT, 48, cycles from core reset deassertion to a stable core prediction (HIDDEN_CNT+CLASS_CNT+1 for the default core); must be ≥1
- TEST_CNT, 1000, samples per batch; counter width CNT_W = $clog2(TEST_CNT+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  sequencer accepts sample this cycle
- in_data  in  FEAT_CNT*FEAT_BITS  packed features, same packing as the core
- in_label  in  PRED_W  expected class (only with TNN_SEQ_ACCURACY_EN)
- core_rst  out  1  reset to core
- core_features  out  FEAT_CNT*FEAT_BITS  registered features to core
- core_prediction  in  PRED_W  core output
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- out_pred  out  PRED_W  captured prediction
- out_correct  out  1  out_pred == label (only with TNN_SEQ_ACCURACY_EN)
- sample_cnt  out  CNT_W  results delivered in batch
- correct_cnt  out  CNT_W  correct results (only with TNN_SEQ_ACCURACY_EN)
- busy  out  1  state != IDLE
- batch_done  out  1  sample_cnt == TEST_CNT

## Operation

- States: IDLE, LOAD, RUN, HOLD.
- IDLE: in_ready = !batch_done. On in_valid&&in_ready, register in_data into core_features (and in_label) and go to LOAD.
- LOAD: one cycle. core_rst=1, wait counter cleared, then go to RUN.
- RUN: wait counter increments every cycle. At count CORE_LAT-1, register core_prediction into out_pred, compute out_correct, and go to HOLD.
- HOLD: out_valid=1, out_pred stable. On out_valid&&out_ready:
  - sample_cnt increments, saturating at TEST_CNT.
  - correct_cnt increments if out_correct.
  - If in_valid and the post-increment count is below TEST_CNT, accept the new sample in the same cycle and go straight to LOAD (in_ready = out_ready && !last). Otherwise go to IDLE.
- core_rst = rst | (state==LOAD).
- core_features change only on an input handshake; they are stable through LOAD, RUN and HOLD.
- batch_done blocks further input. Only rst clears the counters.
- Out-of-range prediction (≥CLASS_CNT) is passed through unchanged and is never counted as correct unless the label matches it exactly.

## Timing

- Reset values:
  - State IDLE.
  - in_ready=1 on the first cycle after reset.
  - out_valid=0, out_pred=0, out_correct=0.
  - core_features=0.
  - sample_cnt=0, correct_cnt=0.
  - busy=0, batch_done=0.
  - core_rst=1 while rst is high.
- Input accepted at edge T: LOAD in cycle T+1, RUN from T+2, out_valid first high in cycle T+CORE_LAT+2.
- Back-to-back throughput: one result per CORE_LAT+2 cycles. From IDLE it is CORE_LAT+3 cycles.
- rst mid-RUN or mid-HOLD: abandon the sample, return to IDLE next cycle, drop out_valid and clear the counters. The core is held in reset for the same cycle.
- out_ready low in HOLD: stall indefinitely, with outputs and counters frozen.

## Configuration

- TNN_SEQ_ACCURACY_EN defined:
  - in_label, out_correct and correct_cnt exist.
  - The label is captured alongside the features.
- TNN_SEQ_ACCURACY_EN undefined:
  - These ports and registers are absent.
  - Sequencing and timing are identical.

## Structure

- Shared package `tnn_seq_pkg`: state enum (IDLE/LOAD/RUN/HOLD), a PRED_W/CNT_W width function, and the default CORE_LAT derivation from HIDDEN_CNT and CLASS_CNT.
- One natural sub-module: `tnn_seq_counters` (sample/correct saturating counters and batch_done). The FSM and wait counter stay in the top.

## Test plan

- Single sample, CORE_LAT=48, core model returns 3, out_ready=1: in_valid at cycle 0 → core_rst high exactly in cycle 1, out_valid in cycle 50 with out_pred=3, sample_cnt 0→1.
- Back-to-back, in_valid and out_ready held high: successive out_valid rises 50 cycles apart; core_features change only on handshake edges.
- Backpressure: out_ready low for 20 cycles in HOLD → out_valid, out_pred and counters stay constant, in_ready=0; release → one handshake only.
- Accuracy (macro on): 4 samples, labels 1,2,3,4 and predictions 1,0,3,6 → correct_cnt=2, out_correct pattern 1,0,1,0. Macro off: ports absent, same timing.
- Batch end, TEST_CNT=3: after 3 results batch_done=1 and in_ready stays 0 with in_valid high. rst → counters 0, in_ready=1.
- rst asserted at cycle 20 of RUN: out_valid never rises for that sample, busy=0 next cycle, core_rst=1 during rst.
